// File: rtl/filter_frame_source.sv
// filter_frame_source: turns an upstream valid/ready pixel stream into
// FRAME_H x FRAME_W rasters for the 2D filter. It emits a frame_start pulse
// before each frame, inserts horizontal and vertical blanking, and keeps
// streaming frames for as long as enable is high at each frame boundary.
module filter_frame_source #(
  parameter int FRAME_H    = 480,
  parameter int FRAME_W    = 640,
  parameter int DATA_WIDTH = 8,
  parameter int HBLANK     = 4,
  parameter int VBLANK     = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  frame_start,
  output logic                  din_vld,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BLK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int COL_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int BLK_W   = (BLK_MAX > 0) ? $clog2(BLK_MAX + 1) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);
  localparam logic [BLK_W-1:0] HB_LAST  = (HBLANK > 0) ? BLK_W'(HBLANK - 1) : '0;
  localparam logic [BLK_W-1:0] VB_LAST  = (VBLANK > 0) ? BLK_W'(VBLANK - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_ACTIVE,
    S_HBLK,
    S_VBLK
  } state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [BLK_W-1:0]        blk_q, blk_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    din_vld_q, din_vld_d;
  logic                    frame_done_q, frame_done_d;

  // Moore decode straight from the state register
  assign frame_start = (state_q == S_SOF);
  assign s_ready     = (state_q == S_ACTIVE);
  assign busy        = (state_q != S_IDLE);
  assign din         = din_q;
  assign din_vld     = din_vld_q;
  assign frame_done  = frame_done_q;

  // Next-state, raster counters and the one-cycle-delayed pixel output
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    blk_d        = blk_q;
    din_d        = din_q;
    din_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SOF;
      end
      S_SOF: begin
        col_d   = '0;
        row_d   = '0;
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (s_valid) begin
          din_d     = s_data;
          din_vld_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            blk_d = '0;
            if (row_q != ROW_LAST) begin
              row_d = row_q + ROW_W'(1);
              if (HBLANK > 0) state_d = S_HBLK;
            end else begin
              frame_done_d = 1'b1;
              if (VBLANK > 0)  state_d = S_VBLK;
              else if (enable) state_d = S_SOF;
              else             state_d = S_IDLE;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_HBLK: begin
        if (blk_q == HB_LAST) begin
          blk_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      S_VBLK: begin
        if (blk_q == VB_LAST) begin
          blk_d   = '0;
          state_d = enable ? S_SOF : S_IDLE;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      blk_q        <= '0;
      din_q        <= '0;
      din_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      blk_q        <= blk_d;
      din_q        <= din_d;
      din_vld_q    <= din_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_filter_frame_source.sv
// Directed bench for filter_frame_source with a 4x3 frame, HBLANK=2, VBLANK=3.
module tb_filter_frame_source;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int HB = 2;
  localparam int VB = 3;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          rst;
  logic          enable;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          frame_start;
  logic          din_vld;
  logic [DW-1:0] din;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int src   = 0;

  always #5 clock = ~clock;

  filter_frame_source #(
    .FRAME_H   (FH),
    .FRAME_W   (FW),
    .DATA_WIDTH(DW),
    .HBLANK    (HB),
    .VBLANK    (VB)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .frame_start(frame_start),
    .din_vld    (din_vld),
    .din        (din),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Upstream source: advance the ramp whenever the handshake completes
  task automatic step();
    logic acc;
    acc = s_valid && s_ready;
    @(posedge clock);
    #1;
    if (acc) src = src + 1;
    s_data = src[DW-1:0];
  endtask

  // Expected {frame_start, s_ready, din_vld, frame_done, busy} at a given
  // cycle offset from frame_start, with s_valid held high (-1 = idle)
  function automatic logic [4:0] exp_frame(int off);
    logic fs, rdy, vld, done, bsy;
    fs   = (off == 0);
    rdy  = (off >= 1 && off <= 4) || (off >= 7 && off <= 10) || (off >= 13 && off <= 16);
    vld  = (off >= 2 && off <= 5) || (off >= 8 && off <= 11) || (off >= 14 && off <= 17);
    done = (off == 17);
    bsy  = (off >= 0 && off <= 19);
    return {fs, rdy, vld, done, bsy};
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    step();
    step();
    got = {frame_start, s_ready, din_vld, frame_done, busy};
    total++;
    if (got !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000", got);
    end
    total++;
    if (din !== '0) begin
      bad++; $display("FAIL reset_din got=%h exp=00", din);
    end
    rst = 1'b0; s_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      total++;
      if (got !== 5'b0) begin
        bad++; $display("FAIL idle_hold c=%0d got=%b exp=00000", c, got);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [4:0] got, exp;
    int pix, n;
    pix = src; n = 0;
    enable = 1'b1; s_valid = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c == 1) enable = 1'b0;
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      exp = exp_frame((c <= 20) ? c - 1 : -1);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL single_ctrl c=%0d got=%b exp=%b", c, got, exp);
      end
      if (din_vld && exp[2]) begin
        total++;
        if (din !== DW'(pix + n)) begin
          bad++; $display("FAIL single_din c=%0d got=%0d exp=%0d", c, din, pix + n);
        end
        n++;
      end
    end
    total++;
    if (n != 12) begin
      bad++; $display("FAIL single_count got=%0d exp=12", n);
    end
  endtask

  task automatic test_continuous();
    logic [4:0] got, exp;
    int pix, n, nfs, ndone, last_fs;
    pix = src; n = 0; nfs = 0; ndone = 0; last_fs = -1;
    enable = 1'b1; s_valid = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (c == 45) enable = 1'b0;
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      exp = exp_frame((c <= 60) ? (c - 1) % 20 : -1);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL cont_ctrl c=%0d got=%b exp=%b", c, got, exp);
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          total++;
          if (c - last_fs != 20) begin
            bad++; $display("FAIL cont_period got=%0d exp=20", c - last_fs);
          end
        end
        last_fs = c; nfs++;
      end
      if (frame_done) ndone++;
      if (din_vld) begin
        total++;
        if (din !== DW'(pix + n)) begin
          bad++; $display("FAIL cont_din c=%0d got=%0d exp=%0d", c, din, pix + n);
        end
        n++;
      end
    end
    total++;
    if (nfs != 3 || n != 36 || ndone != 3) begin
      bad++;
      $display("FAIL cont_counts got fs=%0d pix=%0d done=%0d exp fs=3 pix=36 done=3", nfs, n, ndone);
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] vmask, rmask;
    logic [4:0]  got, exp;
    int vld_at[12] = '{3, 5, 7, 9, 13, 15, 17, 19, 23, 25, 27, 29};
    int pix, n;
    vmask = '0; rmask = '0;
    foreach (vld_at[i]) vmask[vld_at[i]] = 1'b1;
    for (int c = 2; c <= 8; c++)  rmask[c] = 1'b1;
    for (int c = 11; c <= 18; c++) rmask[c] = 1'b1;
    for (int c = 21; c <= 28; c++) rmask[c] = 1'b1;
    pix = src; n = 0;
    enable = 1'b1; s_valid = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (c == 1) enable = 1'b0;
      s_valid = (c % 2 == 0);
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      exp = {c == 1, rmask[c], vmask[c], c == 29, c <= 31};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL bp_ctrl c=%0d got=%b exp=%b", c, got, exp);
      end
      if (din_vld) begin
        total++;
        if (din !== DW'(pix + n)) begin
          bad++; $display("FAIL bp_din c=%0d got=%0d exp=%0d", c, din, pix + n);
        end
        n++;
      end
    end
    total++;
    if (n != 12) begin
      bad++; $display("FAIL bp_count got=%0d exp=12", n);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [4:0] got, exp;
    int pix, n, nfs;
    pix = src; n = 0; nfs = 0;
    enable = 1'b1; s_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 10) enable = 1'b0;
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      exp = exp_frame((c <= 20) ? c - 1 : -1);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL endrop_ctrl c=%0d got=%b exp=%b", c, got, exp);
      end
      if (frame_start) nfs++;
      if (din_vld) begin
        total++;
        if (din !== DW'(pix + n)) begin
          bad++; $display("FAIL endrop_din c=%0d got=%0d exp=%0d", c, din, pix + n);
        end
        n++;
      end
    end
    total++;
    if (nfs != 1 || n != 12) begin
      bad++; $display("FAIL endrop_counts got fs=%0d pix=%0d exp fs=1 pix=12", nfs, n);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] got, exp;
    int pix, n, ndone;
    pix = src; ndone = 0;
    enable = 1'b1; s_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      exp = exp_frame(c - 1);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rstmid_ctrl c=%0d got=%b exp=%b", c, got, exp);
      end
      if (frame_done) ndone++;
    end
    total++;
    if (din !== DW'(pix + 7)) begin
      bad++; $display("FAIL rstmid_pix7 got=%0d exp=%0d", din, pix + 7);
    end
    rst = 1'b1; s_valid = 1'b0; enable = 1'b0;
    step();
    got = {frame_start, s_ready, din_vld, frame_done, busy};
    total++;
    if (got !== 5'b0 || din !== '0 || ndone != 0) begin
      bad++; $display("FAIL rstmid_zero got=%b din=%0d done=%0d exp=00000 din=0 done=0", got, din, ndone);
    end
    rst = 1'b0;
    pix = src; n = 0;
    enable = 1'b1; s_valid = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 1) enable = 1'b0;
      got = {frame_start, s_ready, din_vld, frame_done, busy};
      exp = exp_frame((c <= 20) ? c - 1 : -1);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rerun_ctrl c=%0d got=%b exp=%b", c, got, exp);
      end
      if (din_vld) begin
        total++;
        if (din !== DW'(pix + n)) begin
          bad++; $display("FAIL rerun_din c=%0d got=%0d exp=%0d", c, din, pix + n);
        end
        n++;
      end
    end
    total++;
    if (n != 12) begin
      bad++; $display("FAIL rerun_count got=%0d exp=12", n);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    test_reset();
    test_single_frame();
    test_continuous();
    test_back_pressure();
    test_enable_drop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
